exu_alu_sequencer: RTL

- Sits between IDU and WBU in the EXU. It owns the single shared combinational ALU, which provides ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT and a carry/borrow output.
- Single-cycle ops pass through the ALU and are registered. RV32M DIV/DIVU/REM/REMU are sequenced as a 32-iteration restoring division that reuses the ALU's unsigned SUB for every trial subtraction.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/exu_alu_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/exu_alu_sequencer.sv
// EXU ALU sequencer: owns the shared combinational ALU between IDU and WBU.
// Single-cycle ALU ops are passed through and registered. DIV/DIVU/REM/REMU
// run as a 32-step restoring division that borrows the ALU's unsigned SUB.
module exu_alu_sequencer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned OPT_WIDTH = 13,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPT_WIDTH-1:0] in_opt,
    input  logic                 in_unsigned,
    input  logic                 in_mdu,
    input  logic [1:0]           in_mdu_op,
    input  logic [XLEN-1:0]      in_src1,
    input  logic [XLEN-1:0]      in_src2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_res,
    output logic                 out_carry,
    output logic [XLEN-1:0]      alu_src1,
    output logic [XLEN-1:0]      alu_src2,
    output logic [OPT_WIDTH-1:0] alu_opt,
    output logic                 alu_unsigned,
    input  logic [XLEN-1:0]      alu_res,
    input  logic                 alu_carry
);

    localparam int unsigned CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [OPT_WIDTH-1:0] OPT_SUB  = OPT_WIDTH'(2);
    localparam logic [XLEN-1:0]      MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dividend;
    logic [XLEN-1:0]  divisor;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic             quo_neg;
    logic             rem_neg;
    logic             sel_rem;

    logic             accept;
    logic             mdu_signed;
    logic             src1_neg;
    logic             src2_neg;
    logic [XLEN-1:0]  abs1;
    logic [XLEN-1:0]  abs2;
    logic             div_zero;
    logic             div_ovf;
    logic [CNT_W-1:0] bit_idx;
    logic [XLEN-1:0]  cand;
    logic             take;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready;

    // Operand decode at acceptance: signs, magnitudes and special cases
    always_comb begin
        mdu_signed = ~in_mdu_op[0];
        src1_neg   = mdu_signed & in_src1[XLEN-1];
        src2_neg   = mdu_signed & in_src2[XLEN-1];
        abs1       = src1_neg ? (-in_src1) : in_src1;
        abs2       = src2_neg ? (-in_src2) : in_src2;
        div_zero   = (in_src2 == '0);
        div_ovf    = mdu_signed & (in_src1 == MIN_NEG) & (in_src2 == '1);
    end

    // One restoring-division step: shift in the next dividend bit, trial-subtract
    always_comb begin
        bit_idx = CNT_LAST - cnt;
        cand    = {rem[XLEN-2:0], dividend[bit_idx]};
        take    = rem[XLEN-1] | ~alu_carry;
        quo_fix = quo_neg ? (-quo) : quo;
        rem_fix = rem_neg ? (-rem) : rem;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!in_mdu || div_zero || div_ovf) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_SIGN;
                end
            end
            S_SIGN: state_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ALU port steering: mirror the IDU inputs except while dividing
    always_comb begin
        alu_src1     = in_src1;
        alu_src2     = in_src2;
        alu_opt      = in_opt;
        alu_unsigned = in_unsigned;
        if (state == S_DIV) begin
            alu_src1     = cand;
            alu_src2     = divisor;
            alu_opt      = OPT_SUB;
            alu_unsigned = 1'b1;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
            sel_rem   <= 1'b0;
            out_res   <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!in_mdu) begin
                            out_res   <= alu_res;
                            out_carry <= alu_carry;
                        end else if (div_zero) begin
                            out_res   <= in_mdu_op[1] ? in_src1 : '1;
                            out_carry <= 1'b0;
                        end else if (div_ovf) begin
                            out_res   <= in_mdu_op[1] ? '0 : MIN_NEG;
                            out_carry <= 1'b0;
                        end else begin
                            dividend <= abs1;
                            divisor  <= abs2;
                            quo_neg  <= src1_neg ^ src2_neg;
                            rem_neg  <= src1_neg;
                            sel_rem  <= in_mdu_op[1];
                            rem      <= '0;
                            quo      <= '0;
                            cnt      <= '0;
                        end
                    end
                end
                S_DIV: begin
                    rem <= take ? alu_res : cand;
                    quo <= {quo[XLEN-2:0], take};
                    cnt <= cnt + CNT_W'(1);
                end
                S_SIGN: begin
                    out_res   <= sel_rem ? rem_fix : quo_fix;
                    out_carry <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
